// File: rtl/sequential_divider_if.sv
// Start/done handshake bundle for the sequential divider.
// The div_by_zero signal exists only when DIV_BY_ZERO_CHECK_EN is defined.
interface sequential_divider_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
`ifdef DIV_BY_ZERO_CHECK_EN
    logic             div_by_zero;

    modport master (output start, dividend, divisor,
                    input  ready, done, quotient, remainder, div_by_zero);
    modport slave  (input  start, dividend, divisor,
                    output ready, done, quotient, remainder, div_by_zero);
`else
    modport master (output start, dividend, divisor,
                    input  ready, done, quotient, remainder);
    modport slave  (input  start, dividend, divisor,
                    output ready, done, quotient, remainder);
`endif
endinterface

// File: rtl/sequential_divider.sv
// Unsigned restoring divider, one quotient bit per clock (WIDTH iterations).
// Optional DIV_BY_ZERO_CHECK_EN: zero divisor short-circuits to DONE and flags div_by_zero.
module sequential_divider #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    sequential_divider_if.slave bus
);
    // state | meaning
    // IDLE  | ready=1, waiting for start
    // BUSY  | one shift-subtract iteration per edge, counter counts down
    // DONE  | done=1 for one cycle, results valid
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    // The partial remainder never exceeds the divisor after a step, so its
    // top (sign) bit is always zero and is only carried in shifted/trial.
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             ready_r;
    logic             done_r;
`ifdef DIV_BY_ZERO_CHECK_EN
    logic             dbz_r;
`endif

    assign shifted = {r_reg, q_reg[WIDTH-1]};
    assign trial   = shifted - {1'b0, d_reg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            q_reg   <= '0;
            d_reg   <= '0;
            r_reg   <= '0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
`ifdef DIV_BY_ZERO_CHECK_EN
            dbz_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ready_r <= 1'b0;
                        d_reg   <= bus.divisor;
`ifdef DIV_BY_ZERO_CHECK_EN
                        if (bus.divisor == '0) begin
                            q_reg  <= '1;
                            r_reg  <= bus.dividend;
                            dbz_r  <= 1'b1;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            q_reg   <= bus.dividend;
                            r_reg   <= '0;
                            dbz_r   <= 1'b0;
                            counter <= CW'(WIDTH);
                            state   <= BUSY;
                        end
`else
                        q_reg   <= bus.dividend;
                        r_reg   <= '0;
                        counter <= CW'(WIDTH);
                        state   <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    if (trial[WIDTH] == 1'b0) begin
                        r_reg <= trial[WIDTH-1:0];
                        q_reg <= {q_reg[WIDTH-2:0], 1'b1};
                    end else begin
                        r_reg <= shifted[WIDTH-1:0];
                        q_reg <= {q_reg[WIDTH-2:0], 1'b0};
                    end
                    counter <= counter - CW'(1);
                    if (counter == CW'(1)) begin
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = ready_r;
    assign bus.done      = done_r;
    assign bus.quotient  = q_reg;
    assign bus.remainder = r_reg;
`ifdef DIV_BY_ZERO_CHECK_EN
    assign bus.div_by_zero = dbz_r;
`endif

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider: directed vectors push expected results
// (value, done cycle, div_by_zero flag); a negedge monitor pops and compares on done.
module tb_sequential_divider;
    localparam int W   = 16;
    localparam int LAT = 16;   // posedges from the accepting edge to the done edge

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           t;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_done = 0;
    exp_t sb[$];

    sequential_divider_if #(.WIDTH(W)) bus ();
    sequential_divider #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.done) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("quotient", 32'(bus.quotient), 32'(e.q));
                chk("remainder", 32'(bus.remainder), 32'(e.r));
                chk("done_cycle", 32'(cyc), 32'(e.t));
`ifdef DIV_BY_ZERO_CHECK_EN
                chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
`endif
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    // Drives start for exactly one accepting edge and queues the expected result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input int lat);
        exp_t e;
        wait_ready();
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        e.q = eq; e.r = er; e.dz = edz; e.t = cyc + 1 + lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = $urandom_range(0, 65535);
        bus.divisor  = $urandom_range(0, 65535);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
        wait_ready();
    endtask

    initial begin
        int d0;
        int t0;
        exp_t e;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_quotient", 32'(bus.quotient), 32'd0);
        chk("rst_remainder", 32'(bus.remainder), 32'd0);
`ifdef DIV_BY_ZERO_CHECK_EN
        chk("rst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // 100/7 with ready profile across the whole operation
        issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, LAT);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            chk("ready_busy", 32'(bus.ready), 32'd0);
        end
        @(negedge clk);
        chk("ready_back", 32'(bus.ready), 32'd1);
        wait_idle();

        issue(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, LAT);
        wait_idle();
        issue(16'd5, 16'd10, 16'd0, 16'd5, 1'b0, LAT);
        wait_idle();
        issue(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, LAT);
        wait_idle();

        // divide by zero, then a normal division clears the flag
`ifdef DIV_BY_ZERO_CHECK_EN
        issue(16'h1234, 16'd0, 16'hFFFF, 16'h1234, 1'b1, 0);
`else
        issue(16'h1234, 16'd0, 16'hFFFF, 16'h1234, 1'b0, LAT);
`endif
        wait_idle();
        issue(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, LAT);
        wait_idle();

        // start while busy is ignored
        d0 = n_done;
        issue(16'd50, 16'd6, 16'd8, 16'd2, 1'b0, LAT);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd9; bus.divisor = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        chk("single_done", 32'(n_done - d0), 32'd1);

        // reset mid-division aborts immediately with no done
        issue(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, LAT);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_ready", 32'(bus.ready), 32'd1);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_quotient", 32'(bus.quotient), 32'd0);
        chk("abort_remainder", 32'(bus.remainder), 32'd0);
        sb.delete();
        d0 = n_done;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        issue(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, LAT);
        wait_idle();

        // start held high: results every 18 cycles (43981 / 18 = 2443 r 7)
        wait_ready();
        d0 = n_done;
        bus.start = 1'b1; bus.dividend = 16'hABCD; bus.divisor = 16'h0012;
        t0 = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            e.q = 16'h098B; e.r = 16'h0007; e.dz = 1'b0; e.t = t0 + 18 * k + LAT;
            sb.push_back(e);
        end
        repeat (53) @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        chk("b2b_done_count", 32'(n_done - d0), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
